// File: rtl/fft_pkg.sv
// Shared constants and index helpers for the 32-point FFT datapath.
package fft_pkg;

  localparam int FFT_N      = 32;
  localparam int FFT_LOG2N  = 5;
  localparam int FFT_DATA_W = 16;

  function automatic logic [FFT_LOG2N-1:0] bitrev5(
    input logic [FFT_LOG2N-1:0] i_idx
  );
    logic [FFT_LOG2N-1:0] w_rev;
    for (int b = 0; b < FFT_LOG2N; b++) begin
      w_rev[b] = i_idx[FFT_LOG2N-1-b];
    end
    return w_rev;
  endfunction

endpackage

// File: rtl/fft_pingpong_bank.sv
// One 32-entry complex sample bank: synchronous write, combinational read.
module fft_pingpong_bank
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N      = FFT_N,
  parameter int LOG2N  = FFT_LOG2N
) (
  input  logic              clk_100,
  input  logic              i_we,
  input  logic [LOG2N-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wre,
  input  logic [DATA_W-1:0] i_wim,
  input  logic [LOG2N-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rre,
  output logic [DATA_W-1:0] o_rim
);

  // Storage is intentionally not reset; stale entries are never read.
  logic [DATA_W-1:0] r_mem_re [N];
  logic [DATA_W-1:0] r_mem_im [N];

  always_ff @(posedge clk_100) begin
    if (i_we) begin
      r_mem_re[i_waddr] <= i_wre;
      r_mem_im[i_waddr] <= i_wim;
    end
  end

  assign o_rre = r_mem_re[i_raddr];
  assign o_rim = r_mem_im[i_raddr];

endmodule

// File: rtl/fft_input_reorder.sv
// Ping-pong loader: natural-order samples in, bit-reversed frames out.
module fft_input_reorder
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N      = FFT_N,
  parameter int LOG2N  = FFT_LOG2N
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [LOG2N-1:0]  out_index,
  output logic              out_last
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [LOG2N-1:0] r_wr_ptr;
  logic [LOG2N-1:0] r_rd_ptr;
  logic [1:0]       r_full;

  logic             w_wr_fire;
  logic             w_rd_fire;
  logic             w_wr_last;
  logic             w_rd_last;
  logic [LOG2N-1:0] w_rd_addr;
  logic [1:0]       w_we;

  logic [DATA_W-1:0] w_bank_re [2];
  logic [DATA_W-1:0] w_bank_im [2];

  assign in_ready  = ~r_full[r_wr_bank];
  assign out_valid = r_full[r_rd_bank];

  assign w_wr_fire = in_valid & in_ready;
  assign w_rd_fire = out_valid & out_ready;
  assign w_wr_last = w_wr_fire & (r_wr_ptr == LAST);
  assign w_rd_last = w_rd_fire & (r_rd_ptr == LAST);

  assign w_rd_addr = bitrev5(r_rd_ptr);
  assign w_we      = {w_wr_fire & r_wr_bank, w_wr_fire & ~r_wr_bank};

  for (genvar g = 0; g < 2; g++) begin : g_bank
    fft_pingpong_bank #(
      .DATA_W (DATA_W),
      .N      (N),
      .LOG2N  (LOG2N)
    ) u_bank (
      .clk_100 (clk_100),
      .i_we    (w_we[g]),
      .i_waddr (r_wr_ptr),
      .i_wre   (in_re),
      .i_wim   (in_im),
      .i_raddr (w_rd_addr),
      .o_rre   (w_bank_re[g]),
      .o_rim   (w_bank_im[g])
    );
  end

  assign out_re    = w_bank_re[r_rd_bank];
  assign out_im    = w_bank_im[r_rd_bank];
  assign out_index = w_rd_addr;
  assign out_last  = out_valid & (r_rd_ptr == LAST);

  // Fill and drain always target different banks, so both full updates land.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_full    <= 2'b00;
    end else begin
      if (w_wr_fire) begin
        if (w_wr_last) begin
          r_wr_ptr          <= '0;
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= ~r_wr_bank;
        end else begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
      end
      if (w_rd_fire) begin
        if (w_rd_last) begin
          r_rd_ptr          <= '0;
          r_full[r_rd_bank] <= 1'b0;
          r_rd_bank         <= ~r_rd_bank;
        end else begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_input_reorder.sv
// Bench: frame-level reference model plus directed and random stimulus.
module tb_fft_input_reorder;

  logic        clk_100 = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_re = '0;
  logic [15:0] in_im = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_re;
  logic [15:0] out_im;
  logic [4:0]  out_index;
  logic        out_last;

  fft_input_reorder dut (
    .clk_100   (clk_100),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_index (out_index),
    .out_last  (out_last)
  );

  always #5 clk_100 = ~clk_100;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: every accepted sample in order; frames are complete groups of 32.
  int          n_in  = 0;
  int          n_out = 0;
  logic [31:0] acc[$];

  function automatic int held();
    return n_in / 32 - n_out / 32;
  endfunction

  function automatic int rev5(input int r);
    int v = 0;
    for (int b = 0; b < 5; b++) if (((r >> b) & 1) != 0) v += 16 >> b;
    return v;
  endfunction

  function automatic int exp_pos();
    return (n_out / 32) * 32 + rev5(n_out % 32);
  endfunction

  function automatic logic [15:0] exp_re();
    logic [31:0] s = acc[exp_pos()];
    return s[31:16];
  endfunction

  function automatic logic [15:0] exp_im();
    logic [31:0] s = acc[exp_pos()];
    return s[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      n_in  <= 0;
      n_out <= 0;
      acc.delete();
    end else begin
      if (in_valid && held() < 2) begin
        acc.push_back({in_re, in_im});
        n_in <= n_in + 1;
      end
      if (out_ready && held() >= 1) n_out <= n_out + 1;
    end
  end

  always @(negedge clk_100) begin
    chk("in_ready", 32'(in_ready), 32'(held() < 2));
    chk("out_valid", 32'(out_valid), 32'(held() >= 1));
    if (held() >= 1) begin
      chk("out_re", 32'(out_re), 32'(exp_re()));
      chk("out_im", 32'(out_im), 32'(exp_im()));
      chk("out_index", 32'(out_index), rev5(n_out % 32));
      chk("out_last", 32'(out_last), 32'((n_out % 32) == 31));
    end else begin
      chk("out_last_idle", 32'(out_last), 0);
    end
  end

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && held() > 0; i++) tick();
    chk("drain_done", 32'(out_valid), 0);
  endtask

  task automatic feed_rand(input int n);
    in_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      in_re = 16'($urandom);
      in_im = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
  endtask

  int          exp8 [8] = '{0, 16, 8, 24, 4, 20, 12, 28};
  logic [15:0] got [32];
  int          cnt, vcnt, first, lastc, nlast, lastpos, hs;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk_100);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_index", 32'(out_index), 0);
    chk("rst_out_last", 32'(out_last), 0);

    // Single ramp frame
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_re = 16'(k);
      in_im = 16'(-k);
      tick();
    end
    in_valid = 1'b0;
    chk("latency_valid", 32'(out_valid), 1);
    nlast = 0;
    lastpos = -1;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk_100);
      got[j] = out_re;
      if (out_last) begin
        nlast++;
        lastpos = j;
      end
      tick();
    end
    for (int j = 0; j < 8; j++) chk("ramp_order", 32'(got[j]), exp8[j]);
    chk("ramp_9th", 32'(got[8]), 2);
    chk("ramp_final", 32'(got[31]), 31);
    chk("ramp_nlast", nlast, 1);
    chk("ramp_lastpos", lastpos, 31);

    // Four frames back-to-back
    cnt = 0; vcnt = 0; first = -1; lastc = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 160; i++) begin
      in_valid = (i < 128);
      in_re = 16'($urandom);
      in_im = 16'($urandom);
      @(negedge clk_100);
      if (in_valid && in_ready) cnt++;
      if (out_valid) begin
        vcnt++;
        if (first < 0) first = i;
        lastc = i;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_accepts", cnt, 128);
    chk("b2b_valid_cycles", vcnt, 128);
    chk("b2b_first", first, 32);
    chk("b2b_gapfree", lastc - first, 127);

    // Fill both banks under backpressure
    cnt = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 80; i++) begin
      in_re = 16'($urandom);
      in_im = 16'($urandom);
      @(negedge clk_100);
      if (in_ready) cnt++;
      tick();
    end
    chk("bp_accepts", cnt, 64);
    chk("bp_blocked", 32'(in_ready), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 60 && hs < 32; i++) begin
      @(negedge clk_100);
      if (out_valid) hs++;
      if (hs == 32) chk("bp_ready_before", 32'(in_ready), 0);
      tick();
    end
    chk("bp_handshakes", hs, 32);
    chk("bp_ready_after", 32'(in_ready), 1);
    drain();

    // Stall at rd_ptr 7
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_re = 16'(300 + k);
      in_im = 16'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (7) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_100);
      chk("stall_index", 32'(out_index), 28);
      chk("stall_re", 32'(out_re), 328);
      tick();
    end
    drain();

    // Reset with a half-drained frame and a partial frame
    out_ready = 1'b0;
    feed_rand(32);
    out_ready = 1'b1;
    feed_rand(16);
    out_ready = 1'b0;
    feed_rand(4);
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 0);
    chk("rst_mid_in_ready", 32'(in_ready), 1);
    chk("rst_mid_out_last", 32'(out_last), 0);
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_re = 16'(100 + k);
      in_im = 16'(k);
      tick();
    end
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_index", 32'(out_index), 0);
    chk("post_rst_re", 32'(out_re), 100);
    drain();

    // Last write of frame 2 coincides with last read of frame 1
    out_ready = 1'b0;
    feed_rand(32);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_re = 16'(200 + k);
      in_im = 16'(k);
      @(negedge clk_100);
      if (k == 31) begin
        chk("sim_last", 32'(out_last), 1);
        chk("sim_in_ready", 32'(in_ready), 1);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("sim_next_valid", 32'(out_valid), 1);
    chk("sim_next_index", 32'(out_index), 0);
    chk("sim_next_re", 32'(out_re), 200);
    chk("sim_next_in_ready", 32'(in_ready), 1);
    drain();

    // Random traffic
    for (int blk = 0; blk < 6; blk++) begin
      int pin  = $urandom_range(20, 100);
      int pout = $urandom_range(20, 100);
      for (int i = 0; i < 500; i++) begin
        in_valid  = ($urandom_range(0, 99) < pin);
        out_ready = ($urandom_range(0, 99) < pout);
        in_re = 16'($urandom);
        in_im = 16'($urandom);
        tick();
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
